// File: rtl/seg7_time_monitor_if.sv
// -----------------------------------------------------------------------------
// seg7_time_monitor_if
// Six-digit seven-segment timer display bus.
//   seg_in    : [5:0][6:0] segment bus. Digit order [0] sec units, [1] sec tens,
//               [2] min units, [3] min tens, [4] hr units, [5] hr tens.
//               Segment bits are {a,b,c,d,e,f,g}, MSB first, active-low.
//   sample_en : capture strobe; seg_in is valid in the same cycle.
// The timer (or bench) drives through the master modport; the monitor
// receives through the slave modport.
// -----------------------------------------------------------------------------
interface seg7_time_monitor_if;
    logic [5:0][6:0] seg_in;
    logic            sample_en;

    modport master (output seg_in, output sample_en);
    modport slave  (input  seg_in, input  sample_en);
endinterface

// File: rtl/seg7_time_monitor.sv
// -----------------------------------------------------------------------------
// seg7_time_monitor
// Observer for the six-digit seven-segment timer display. Each strobed sample
// is decoded back to BCD, range-checked as HH:MM:SS, converted to seconds and
// checked for a legal advance relative to the previous good sample.
//
// Ports:
//   sys_clk    : clock, rising edge
//   rst        : asynchronous, active-high reset
//   disp       : display bus (slave side): seg_in, sample_en
//   clear      : synchronous clear of sticky flags, step counter, tracking FSM
//   bcd_out    : decoded digits of the last good sample
//   time_sec   : hr*3600 + min*60 + sec of the last good sample
//   time_valid : one-cycle pulse, good sample published
//   sample_bad : one-cycle pulse, sample failed decode or range check
//   seg_err    : sticky, illegal segment pattern seen
//   range_err  : sticky, digits decoded but value out of range
//   step_err   : sticky, illegal advance between good samples
//   step_count : count of legal +1 s advances, saturating
//
// Pipeline: S1 captures seg_in, S2 holds decoded digits and error bits,
// S3 (combinational from S2) computes seconds and the step check into the
// output registers. sample_en in cycle N shows up on the outputs in N+3.
// -----------------------------------------------------------------------------
module seg7_time_monitor #(
    parameter int WRAP_HOURS = 24
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    seg7_time_monitor_if.slave   disp,
    input  logic                 clear,
    output logic [5:0][3:0]      bcd_out,
    output logic [16:0]          time_sec,
    output logic                 time_valid,
    output logic                 sample_bad,
    output logic                 seg_err,
    output logic                 range_err,
    output logic                 step_err,
    output logic [15:0]          step_count
);

    typedef enum logic {IDLE, TRACK} state_t;

    // Last second of the day; the only value from which 0 is a legal +1 step.
    localparam logic [16:0] LAST_SEC   = 17'(WRAP_HOURS * 3600 - 1);
    localparam logic [6:0]  WRAP_LIMIT = 7'(WRAP_HOURS);

    // Returns {legal, digit}; patterns are active-low {a,b,c,d,e,f,g}.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b0000001: return {1'b1, 4'd0};
            7'b1001111: return {1'b1, 4'd1};
            7'b0010010: return {1'b1, 4'd2};
            7'b0000110: return {1'b1, 4'd3};
            7'b1001100: return {1'b1, 4'd4};
            7'b0100100: return {1'b1, 4'd5};
            7'b0100000: return {1'b1, 4'd6};
            7'b0001111: return {1'b1, 4'd7};
            7'b0000000: return {1'b1, 4'd8};
            7'b0000100: return {1'b1, 4'd9};
            default:    return {1'b0, 4'd0};
        endcase
    endfunction

    // ---------------------------------------------------------------- S1
    logic            s1_valid_q, s1_valid_d;
    logic [5:0][6:0] s1_seg_q,   s1_seg_d;

    // ---------------------------------------------------------------- S2
    logic            s2_valid_q,     s2_valid_d;
    logic [5:0][3:0] s2_bcd_q,       s2_bcd_d;
    logic            s2_seg_bad_q,   s2_seg_bad_d;
    logic            s2_range_bad_q, s2_range_bad_d;

    logic [5:0]      dec_legal;
    logic [5:0][3:0] dec_bcd;
    logic [6:0]      dec_hours;
    logic            dec_range_ok;

    // ------------------------------------------------------- S3 / outputs
    state_t          state_q,      state_d;
    logic [5:0][3:0] bcd_q,        bcd_d;
    logic [16:0]     time_sec_q,   time_sec_d;
    logic            time_valid_q, time_valid_d;
    logic            sample_bad_q, sample_bad_d;
    logic            seg_err_q,    seg_err_d;
    logic            range_err_q,  range_err_d;
    logic            step_err_q,   step_err_d;
    logic [15:0]     step_count_q, step_count_d;

    logic [16:0]     sec_part, min_part, hr_part, new_sec;
    logic            s2_good;

    // S1: capture the bus only on the strobe so the decoded value is stable.
    // NOTE: every variable written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        s1_valid_d = disp.sample_en;
        s1_seg_d   = s1_seg_q;
        if (disp.sample_en) begin
            s1_seg_d = disp.seg_in;
        end
    end

    // S2: decode all six digits, then range check. A range error is only
    // meaningful when every digit decoded, so it is masked by dec_legal.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            {dec_legal[i], dec_bcd[i]} = seg_decode(s1_seg_q[i]);
        end
        dec_hours    = {3'b000, dec_bcd[5]} * 7'd10 + {3'b000, dec_bcd[4]};
        dec_range_ok = (dec_bcd[1] <= 4'd5) && (dec_bcd[3] <= 4'd5) &&
                       (dec_hours < WRAP_LIMIT);

        s2_valid_d     = s1_valid_q;
        s2_bcd_d       = dec_bcd;
        s2_seg_bad_d   = ~&dec_legal;
        s2_range_bad_d = (&dec_legal) & ~dec_range_ok;
    end

    // S3: seconds from BCD, constant multiplies only.
    assign sec_part = {13'd0, s2_bcd_q[1]} * 17'd10 + {13'd0, s2_bcd_q[0]};
    assign min_part = ({13'd0, s2_bcd_q[3]} * 17'd10 + {13'd0, s2_bcd_q[2]}) * 17'd60;
    assign hr_part  = ({13'd0, s2_bcd_q[5]} * 17'd10 + {13'd0, s2_bcd_q[4]}) * 17'd3600;
    assign new_sec  = hr_part + min_part + sec_part;
    assign s2_good  = s2_valid_q & ~s2_seg_bad_q & ~s2_range_bad_q;

    // Tracking FSM next-state and output-register logic.
    always_comb begin
        state_d      = state_q;
        bcd_d        = bcd_q;
        time_sec_d   = time_sec_q;
        time_valid_d = 1'b0;
        sample_bad_d = 1'b0;
        seg_err_d    = seg_err_q;
        range_err_d  = range_err_q;
        step_err_d   = step_err_q;
        step_count_d = step_count_q;

        if (s2_valid_q) begin
            if (s2_good) begin
                time_valid_d = 1'b1;
                bcd_d        = s2_bcd_q;
                time_sec_d   = new_sec;
                state_d      = TRACK;
                // An unchanged value is a legal repeat; a jump to 0 that is
                // not the day wrap is taken as the timer being reset.
                if (state_q == TRACK && new_sec != time_sec_q) begin
                    if (new_sec == time_sec_q + 17'd1 ||
                        (time_sec_q == LAST_SEC && new_sec == 17'd0)) begin
                        if (step_count_q != 16'hFFFF) begin
                            step_count_d = step_count_q + 16'd1;
                        end
                    end else if (new_sec != 17'd0) begin
                        step_err_d = 1'b1;
                    end
                end
            end else begin
                sample_bad_d = 1'b1;
                seg_err_d    = seg_err_q   | s2_seg_bad_q;
                range_err_d  = range_err_q | s2_range_bad_q;
                state_d      = IDLE;
            end
        end

        // clear overrides flag and counter updates, but a result arriving in
        // the same cycle is still published above.
        if (clear) begin
            seg_err_d    = 1'b0;
            range_err_d  = 1'b0;
            step_err_d   = 1'b0;
            step_count_d = 16'd0;
            state_d      = IDLE;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_seg_q       <= '0;
            s2_valid_q     <= 1'b0;
            s2_bcd_q       <= '0;
            s2_seg_bad_q   <= 1'b0;
            s2_range_bad_q <= 1'b0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_seg_q       <= s1_seg_d;
            s2_valid_q     <= s2_valid_d;
            s2_bcd_q       <= s2_bcd_d;
            s2_seg_bad_q   <= s2_seg_bad_d;
            s2_range_bad_q <= s2_range_bad_d;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bcd_q        <= '0;
            time_sec_q   <= 17'd0;
            time_valid_q <= 1'b0;
            sample_bad_q <= 1'b0;
            seg_err_q    <= 1'b0;
            range_err_q  <= 1'b0;
            step_err_q   <= 1'b0;
            step_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            bcd_q        <= bcd_d;
            time_sec_q   <= time_sec_d;
            time_valid_q <= time_valid_d;
            sample_bad_q <= sample_bad_d;
            seg_err_q    <= seg_err_d;
            range_err_q  <= range_err_d;
            step_err_q   <= step_err_d;
            step_count_q <= step_count_d;
        end
    end

    assign bcd_out    = bcd_q;
    assign time_sec   = time_sec_q;
    assign time_valid = time_valid_q;
    assign sample_bad = sample_bad_q;
    assign seg_err    = seg_err_q;
    assign range_err  = range_err_q;
    assign step_err   = step_err_q;
    assign step_count = step_count_q;

endmodule
